// File: rtl/cdb_pkg.sv
// cdb_pkg: shared defaults, result-entry layout and the invalid-PC marker for the multi-lane CDB.
package cdb_pkg;
    localparam int NUM_FU_DEF      = 4;
    localparam int NUM_CDB_DEF     = 2;
    localparam int QUEUE_DEPTH_DEF = 4;
    localparam int XLEN_DEF        = 32;
    localparam int PRF_LEN_DEF     = 6;
    localparam int ROB_LEN_DEF     = 5;
    localparam int SIDE_W_DEF      = 8;
    localparam logic [31:0] PC_INVALID = 32'hfacebeec;
    // Field order here is the packing order used for the flat FIFO words.
    typedef struct packed {
        logic [XLEN_DEF-1:0]    value;
        logic [PRF_LEN_DEF-1:0] prf_idx;
        logic [ROB_LEN_DEF-1:0] rob_idx;
        logic [XLEN_DEF-1:0]    pc;
        logic [SIDE_W_DEF-1:0]  side;
    } CDB_ENTRY;
endpackage

// File: rtl/cdb_chan_fifo.sv
// cdb_chan_fifo: per-channel result FIFO with head/tail pointers, occupancy count and synchronous flush.
module cdb_chan_fifo #(
    parameter int W     = 83,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    assign head  = mem[rd_ptr];
    assign full  = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/cdb_multi_arbiter.sv
// cdb_multi_arbiter: per-channel FIFOs feeding NUM_CDB round-robin broadcast lanes with bypass.
// Define CDB_STATS_EN to add per-channel stall_cnt/full_cnt saturating counters.
module cdb_multi_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU      = NUM_FU_DEF,
    parameter int NUM_CDB     = NUM_CDB_DEF,
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF,
    parameter int XLEN        = XLEN_DEF,
    parameter int PRF_LEN     = PRF_LEN_DEF,
    parameter int ROB_LEN     = ROB_LEN_DEF,
    parameter int SIDE_W      = SIDE_W_DEF
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               flush,
    input  logic [NUM_FU-1:0]                  fu_valid,
    output logic [NUM_FU-1:0]                  fu_ready,
    input  logic [NUM_FU*XLEN-1:0]             fu_value,
    input  logic [NUM_FU*PRF_LEN-1:0]          fu_prf_idx,
    input  logic [NUM_FU*ROB_LEN-1:0]          fu_rob_idx,
    input  logic [NUM_FU*XLEN-1:0]             fu_PC,
    input  logic [NUM_FU*SIDE_W-1:0]           fu_side,
    output logic [NUM_CDB-1:0]                 cdb_valid,
    output logic [NUM_CDB*XLEN-1:0]            cdb_value,
    output logic [NUM_CDB*PRF_LEN-1:0]         cdb_prf_idx,
    output logic [NUM_CDB*ROB_LEN-1:0]         cdb_rob_idx,
    output logic [NUM_CDB*XLEN-1:0]            cdb_PC,
    output logic [NUM_CDB*SIDE_W-1:0]          cdb_side,
    output logic [NUM_CDB*$clog2(NUM_FU)-1:0]  cdb_src
`ifdef CDB_STATS_EN
    ,
    output logic [NUM_FU*32-1:0]               stall_cnt,
    output logic [NUM_FU*32-1:0]               full_cnt
`endif
);
    localparam int SRC_W = $clog2(NUM_FU);
    localparam int EW    = 2*XLEN + PRF_LEN + ROB_LEN + SIDE_W;
    localparam logic [EW-1:0] IDLE = {{(XLEN+PRF_LEN+ROB_LEN){1'b0}}, XLEN'(PC_INVALID), {SIDE_W{1'b0}}};
    logic [EW-1:0]     din [NUM_FU];
    logic [EW-1:0]     head [NUM_FU];
    logic [EW-1:0]     cand [NUM_FU];
    logic [EW-1:0]     lane_ent [NUM_CDB];
    logic [SRC_W-1:0]  lane_src [NUM_CDB];
    logic [NUM_CDB-1:0] lane_v;
    logic [NUM_FU-1:0] req, req_rot, grant, push, pop, full, empty;
    logic [SRC_W-1:0]  rr_ptr, next_rr;
    logic              kill;
    int                n, idx;
    assign kill = reset || flush;
    for (genvar i = 0; i < NUM_FU; i++) begin : g_chan
        assign din[i]      = {fu_value[i*XLEN +: XLEN], fu_prf_idx[i*PRF_LEN +: PRF_LEN],
                              fu_rob_idx[i*ROB_LEN +: ROB_LEN], fu_PC[i*XLEN +: XLEN],
                              fu_side[i*SIDE_W +: SIDE_W]};
        assign fu_ready[i] = !full[i];
        assign req[i]      = !empty[i] || fu_valid[i];
        assign cand[i]     = empty[i] ? din[i] : head[i];
        assign pop[i]      = grant[i] && !empty[i];
        // A granted empty channel forwards its input directly instead of queueing it.
        assign push[i]     = fu_valid[i] && !full[i] && !(grant[i] && empty[i]);
        cdb_chan_fifo #(.W(EW), .DEPTH(QUEUE_DEPTH)) u_fifo (
            .clock(clock), .reset(reset), .flush(flush), .push(push[i]), .pop(pop[i]),
            .din(din[i]), .head(head[i]), .full(full[i]), .empty(empty[i])
        );
        a_no_push_when_full: assert property (@(posedge clock) disable iff (reset) !(fu_valid[i] && full[i]));
    end
    always_comb begin
        grant   = '0;
        lane_v  = '0;
        next_rr = rr_ptr;
        n       = 0;
        idx     = 0;
        for (int k = 0; k < NUM_CDB; k++) lane_src[k] = '0;
        req_rot = NUM_FU'({req, req} >> rr_ptr);
        for (int j = 0; j < NUM_FU; j++) begin
            if (req_rot[j] && n < NUM_CDB) begin
                idx   = int'(rr_ptr) + j;
                idx   = idx >= NUM_FU ? idx - NUM_FU : idx;
                grant = grant | (NUM_FU'(1) << idx);
                for (int k = 0; k < NUM_CDB; k++) begin
                    lane_v[k]   = k == n ? 1'b1 : lane_v[k];
                    lane_src[k] = k == n ? SRC_W'(idx) : lane_src[k];
                end
                next_rr = idx == NUM_FU - 1 ? '0 : SRC_W'(idx + 1);
                n++;
            end
        end
    end
    for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
        assign lane_ent[k] = lane_v[k] ? cand[lane_src[k]] : IDLE;
    end
    always_ff @(posedge clock) begin
        cdb_valid <= kill ? '0 : lane_v;
        rr_ptr    <= kill ? '0 : next_rr;
        for (int k = 0; k < NUM_CDB; k++) begin
            {cdb_value[k*XLEN +: XLEN], cdb_prf_idx[k*PRF_LEN +: PRF_LEN], cdb_rob_idx[k*ROB_LEN +: ROB_LEN],
             cdb_PC[k*XLEN +: XLEN], cdb_side[k*SIDE_W +: SIDE_W]} <= kill ? IDLE : lane_ent[k];
            cdb_src[k*SRC_W +: SRC_W] <= kill ? '0 : lane_src[k];
        end
    end
`ifdef CDB_STATS_EN
    // Statistics survive flush so mispredict storms remain visible.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (reset) begin
                stall_cnt[i*32 +: 32] <= '0;
                full_cnt[i*32 +: 32]  <= '0;
            end else begin
                if (req[i] && !grant[i] && stall_cnt[i*32 +: 32] != '1)
                    stall_cnt[i*32 +: 32] <= stall_cnt[i*32 +: 32] + 32'd1;
                if (full[i] && full_cnt[i*32 +: 32] != '1)
                    full_cnt[i*32 +: 32] <= full_cnt[i*32 +: 32] + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_cdb_multi_arbiter.sv
// tb_cdb_multi_arbiter: random traffic against a queue-based model of the multi-lane CDB.
module tb_cdb_multi_arbiter;
    typedef struct {
        logic [31:0] value;
        logic [5:0]  prf;
        logic [4:0]  rob;
        logic [31:0] pc;
        logic [7:0]  side;
    } ent_t;
    logic        clock = 1'b0;
    logic        reset, flush;
    logic [3:0]  fu_valid, fu_ready;
    logic [127:0] fu_value, fu_PC;
    logic [23:0] fu_prf_idx;
    logic [19:0] fu_rob_idx;
    logic [31:0] fu_side;
    logic [1:0]  cdb_valid;
    logic [63:0] cdb_value, cdb_PC;
    logic [11:0] cdb_prf_idx;
    logic [9:0]  cdb_rob_idx;
    logic [15:0] cdb_side;
    logic [3:0]  cdb_src;
`ifdef CDB_STATS_EN
    logic [127:0] stall_cnt, full_cnt;
`endif
    ent_t in_e [4];
    ent_t q [4][$];
    int   rr;
    logic exp_v [2];
    logic [1:0] exp_src [2];
    ent_t exp_e [2];
    int   stall_m [4];
    int   full_m [4];
    int   checks = 0;
    int   errors = 0;

    cdb_multi_arbiter dut (
        .clock(clock), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_value(fu_value),
        .fu_prf_idx(fu_prf_idx), .fu_rob_idx(fu_rob_idx), .fu_PC(fu_PC), .fu_side(fu_side),
        .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_prf_idx(cdb_prf_idx),
        .cdb_rob_idx(cdb_rob_idx), .cdb_PC(cdb_PC), .cdb_side(cdb_side), .cdb_src(cdb_src)
`ifdef CDB_STATS_EN
        , .stall_cnt(stall_cnt), .full_cnt(full_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic v, input logic [1:0] s, input ent_t e);
        return {42'd0, v, s, e.value, e.prf, e.rob, e.pc, e.side};
    endfunction

    function automatic ent_t idle_ent();
        ent_t e;
        e = '{value: 32'd0, prf: 6'd0, rob: 5'd0, pc: 32'hfacebeec, side: 8'd0};
        return e;
    endfunction

    function automatic logic [127:0] dut_lane(input int k);
        ent_t e;
        e = '{value: cdb_value[k*32 +: 32], prf: cdb_prf_idx[k*6 +: 6], rob: cdb_rob_idx[k*5 +: 5],
              pc: cdb_PC[k*32 +: 32], side: cdb_side[k*8 +: 8]};
        return pack(cdb_valid[k], cdb_src[k*2 +: 2], e);
    endfunction

    task automatic set_idle_outputs();
        for (int k = 0; k < 2; k++) begin
            exp_v[k] = 1'b0; exp_src[k] = 2'd0; exp_e[k] = idle_ent();
        end
    endtask

    // Model of one clock edge: oldest-first broadcast, round-robin over channels, at most two per cycle.
    task automatic step_model(input logic rst, input logic fl);
        int sz [4];
        logic g [4];
        int lane_c [2];
        int n, last;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin q[i].delete(); stall_m[i] = 0; full_m[i] = 0; end
            rr = 0;
            set_idle_outputs();
            return;
        end
        n = 0; last = 0;
        for (int i = 0; i < 4; i++) begin sz[i] = q[i].size(); g[i] = 1'b0; end
        for (int j = 0; j < 4; j++) begin
            int c;
            c = (rr + j) % 4;
            if ((sz[c] > 0 || fu_valid[c]) && n < 2) begin
                g[c] = 1'b1; lane_c[n] = c; n++; last = c;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if ((sz[i] > 0 || fu_valid[i]) && !g[i]) stall_m[i]++;
            if (sz[i] == 4) full_m[i]++;
        end
        if (fl) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            rr = 0;
            set_idle_outputs();
            return;
        end
        set_idle_outputs();
        for (int k = 0; k < n; k++) begin
            exp_v[k] = 1'b1;
            exp_src[k] = 2'(lane_c[k]);
            exp_e[k] = sz[lane_c[k]] > 0 ? q[lane_c[k]][0] : in_e[lane_c[k]];
        end
        if (n > 0) rr = (last + 1) % 4;
        for (int i = 0; i < 4; i++) begin
            if (g[i] && sz[i] > 0) void'(q[i].pop_front());
            if (fu_valid[i] && sz[i] < 4 && !(g[i] && sz[i] == 0)) q[i].push_back(in_e[i]);
        end
    endtask

    task automatic cycle(input logic [3:0] v, input logic fl, input logic rst);
        logic [3:0] rdy;
        for (int i = 0; i < 4; i++) begin
            in_e[i] = '{value: $urandom, prf: 6'($urandom), rob: 5'($urandom), pc: $urandom, side: 8'($urandom)};
            fu_value[i*32 +: 32] = in_e[i].value;
            fu_prf_idx[i*6 +: 6] = in_e[i].prf;
            fu_rob_idx[i*5 +: 5] = in_e[i].rob;
            fu_PC[i*32 +: 32]    = in_e[i].pc;
            fu_side[i*8 +: 8]    = in_e[i].side;
            rdy[i] = q[i].size() < 4;
        end
        reset = rst;
        flush = fl;
        fu_valid = v & rdy;
        step_model(rst, fl);
        @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 2; k++)
            check($sformatf("lane%0d", k), dut_lane(k), pack(exp_v[k], exp_src[k], exp_e[k]));
        for (int i = 0; i < 4; i++) rdy[i] = q[i].size() < 4;
        check("fu_ready", {124'd0, fu_ready}, {124'd0, rdy});
    endtask

    initial begin
        int dens;
        reset = 1'b1; flush = 1'b0; fu_valid = '0;
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        check("reset_ready", {124'd0, fu_ready}, 128'hf);
        check("reset_pc", {64'd0, cdb_PC}, {64'd0, 32'hfacebeec, 32'hfacebeec});
        cycle(4'b0101, 1'b0, 1'b0);
        check("bypass_src", {124'd0, cdb_src}, {124'd0, 2'd2, 2'd0});
        check("bypass_valid", {126'd0, cdb_valid}, 128'h3);
        for (int c = 0; c < 3; c++) cycle(4'b1111, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) cycle(4'b1111, 1'b0, 1'b0);
        check("saturated_ready1", {127'd0, fu_ready[1]}, 128'd0);
        cycle(4'b1111, 1'b1, 1'b0);
        check("flush_valid", {126'd0, cdb_valid}, 128'd0);
        check("flush_ready", {124'd0, fu_ready}, 128'hf);
        cycle(4'b0000, 1'b0, 1'b0);
        check("post_flush_valid", {126'd0, cdb_valid}, 128'd0);
        dens = 50;
        for (int c = 0; c < 800; c++) begin
            logic [3:0] v;
            if (c % 100 == 0) dens = $urandom_range(20, 100);
            for (int i = 0; i < 4; i++) v[i] = $urandom_range(0, 99) < dens;
            cycle(v, $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
        end
`ifdef CDB_STATS_EN
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall_cnt%0d", i), {96'd0, stall_cnt[i*32 +: 32]}, 128'(stall_m[i]));
            check($sformatf("full_cnt%0d", i), {96'd0, full_cnt[i*32 +: 32]}, 128'(full_m[i]));
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_multi_arbiter.md
Name: cdb_multi_arbiter

Overview:
- Parametrised common data bus that collects results from NUM_FU functional-unit channels into per-channel FIFOs.
- Each cycle it grants up to NUM_CDB broadcast lanes, round-robin across channels, and drives registered broadcasts to the PRF, RS wakeup and ROB.
- Adds what the single-lane design lacks: multiple lanes, per-channel backpressure (fu_ready), fairness, and a generic branch sideband field.
- Sits between the FU outputs and the ROB/RS/PRF writeback.

Parameters:
- NUM_FU, 4, number of producer channels (ALU, MUL, MEM, BR...).
- NUM_CDB, 2, broadcast lanes per cycle; must be 1..NUM_FU.
- QUEUE_DEPTH, 4, entries per channel FIFO; must be a power of 2, ≥2.
- XLEN, 32, data/PC width.
- PRF_LEN, 6, physical register index width.
- ROB_LEN, 5, ROB index width.
- SIDE_W, 8, opaque sideband bits (branch direction, mispredict, predictor bits) carried unchanged.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  commit-time mispredict; synchronous squash
- fu_valid  in  NUM_FU  result present on channel i
- fu_ready  out  NUM_FU  channel i FIFO can accept a push this cycle
- fu_value  in  NUM_FU*XLEN  result value per channel
- fu_prf_idx  in  NUM_FU*PRF_LEN  destination preg
- fu_rob_idx  in  NUM_FU*ROB_LEN  ROB entry
- fu_PC  in  NUM_FU*XLEN  instruction PC
- fu_side  in  NUM_FU*SIDE_W  sideband
- cdb_valid  out  NUM_CDB  lane k broadcasting
- cdb_value  out  NUM_CDB*XLEN
- cdb_prf_idx  out  NUM_CDB*PRF_LEN
- cdb_rob_idx  out  NUM_CDB*ROB_LEN
- cdb_PC  out  NUM_CDB*XLEN
- cdb_side  out  NUM_CDB*SIDE_W
- cdb_src  out  NUM_CDB*$clog2(NUM_FU)  originating channel per lane

Behaviour:
- Reset or flush, on the same edge:
  - cdb_valid=0, value/prf/rob/side/src=0, cdb_PC=32'hfacebeec.
  - All FIFO pointers and counts cleared; RR pointer=0.
  - fu_valid in that cycle is dropped.
- FIFO per channel: head/tail pointers plus count (0..QUEUE_DEPTH).
  - fu_ready = (count != QUEUE_DEPTH); depends on registered count only, no pop-through.
- Push: fu_valid && fu_ready.
  - fu_valid while !fu_ready is a protocol violation: input dropped, assertion fires.
- Eligibility: channel i requests if count>0, or (count==0 && fu_valid[i]) as a bypass.
  - The candidate is the FIFO head, else the bypass input.
- Arbitration:
  - Scan channels starting at rr_ptr, wrapping; grant first NUM_CDB requesters, lane 0 = first found.
  - At most one grant per channel per cycle.
  - Next rr_ptr = (last granted index + 1) mod NUM_FU; unchanged if no grant.
- Granted channel:
  - Head popped when count>0.
  - On bypass, the entry is not written into the FIFO.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Lanes fill from 0 upward; unused lanes have cdb_valid=0 and data 0.
- Latency: bypass input appears on cdb_* exactly 1 cycle later. Queued entries broadcast in FIFO order per channel.
- Wrap: pointers wrap naturally at QUEUE_DEPTH.
- Flush has priority over push/pop. Outputs are registered, so a broadcast already on the bus in the flush cycle still completes that cycle.

Optional Feature:
- CDB_STATS_EN defined:
  - Adds output stall_cnt (NUM_FU*32): per-channel counter of cycles with request && !grant.
  - Also adds output full_cnt (NUM_FU*32): cycles with count==QUEUE_DEPTH.
  - Both counters saturate and clear on reset only, not on flush.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package cdb_pkg:
  - CDB_ENTRY struct (value, prf_idx, rob_idx, PC, side).
  - Default parameter constants and the facebeec PC-invalid constant.
- Sub-module cdb_chan_fifo: one per channel via generate.
  - Push/pop, count, full/empty, head entry, flush.
- Arbiter, bypass mux and output registers stay in the top.

Test Plan:
- NUM_FU=4, NUM_CDB=2, all empty; fu_valid=4'b0101 at cycle 0 -> cycle 1: lane0 src0, lane1 src2, both valid, FIFOs stay empty.
- Hold fu_valid=4'b1111 for 3 cycles:
  - Grants rotate {0,1},{2,3},{0,1}...
  - Counts peak at 2.
  - Each channel's rob_idx broadcast in push order.
- Channel 1 pushes 4 entries while the others saturate the lanes -> fu_ready[1]=0 at count 4; the 5th push is not accepted and the assertion fires.
- Assert flush with 3 entries queued and fu_valid=1 -> next cycle cdb_valid=0, cdb_PC=32'hfacebeec, all fu_ready=1, no stale broadcast afterwards.
- Simultaneous push and pop on a channel at count 2 -> count stays 2, pointer wraps from 3 to 0 with correct data.
- Build with CDB_STATS_EN, starve channel 3 for 5 cycles -> stall_cnt[3]=5.
